// File: rtl/character_registers_if.sv
// ----------------------------------------------------------------------------
// character_registers_if
//   Move-request handshake between the upstream game logic and the
//   character position store.
//
//   Signals
//     hold        1 = stall new moves (display frame in progress)
//     move_valid  move request present
//     move_id     character to move (0 = pacman, 1..4 = ghosts)
//     move_dir    0 = left, 1 = right, 2 = up, 3 = down
//     move_ready  store can accept a move this cycle
//
//   Modports
//     master  upstream game logic (drives the request)
//     slave   character_registers (answers with move_ready)
// ----------------------------------------------------------------------------
interface character_registers_if;
    logic       hold;
    logic       move_valid;
    logic [2:0] move_id;
    logic [1:0] move_dir;
    logic       move_ready;

    modport master (
        output hold,
        output move_valid,
        output move_id,
        output move_dir,
        input  move_ready
    );

    modport slave (
        input  hold,
        input  move_valid,
        input  move_id,
        input  move_dir,
        output move_ready
    );
endinterface

// File: rtl/character_registers.sv
// ----------------------------------------------------------------------------
// character_registers
//   Position store for the five on-screen characters (id 0 = pacman,
//   ids 1..4 = ghosts). Moves arrive over a valid/ready handshake and are
//   processed by a four-state FSM: IDLE -> CALC -> WRITE -> COLLIDE -> IDLE,
//   so one move is accepted every four cycles. Moves clamp at the grid edges
//   and a sticky flag records any pacman/ghost overlap.
//
//   Optional feature
//     CHARACTER_REGISTERS_WRAP_TUNNEL_EN  defined: horizontal moves wrap
//                                         around the grid (tunnel);
//                                         vertical moves always clamp.
//
//   Ports
//     clock_50            system clock, rising edge
//     reset               synchronous, active-high
//     character_type      read index from the display stage
//     char_x, char_y      position of the indexed character (combinational,
//                         zero-extended, 0/0 for indices 5..7)
//     pacman_orientation  0 = facing left, 1 = facing right
//     mv                  move handshake (hold/valid/id/dir/ready)
//     collision           sticky pacman/ghost overlap flag
//     collision_clear     clears collision at the next edge (a set wins)
// ----------------------------------------------------------------------------
module character_registers #(
    parameter int GRID_W   = 22,
    parameter int GRID_H   = 16,
    parameter int PAC_X0   = 10,
    parameter int PAC_Y0   = 12,
    parameter int GHOST_X0 = 9,
    parameter int GHOST_Y0 = 6
) (
    input  logic                        clock_50,
    input  logic                        reset,
    input  logic [2:0]                  character_type,
    output logic [7:0]                  char_x,
    output logic [7:0]                  char_y,
    output logic                        pacman_orientation,
    character_registers_if.slave        mv,
    output logic                        collision,
    input  logic                        collision_clear
);

`ifdef CHARACTER_REGISTERS_WRAP_TUNNEL_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int         NUM_CHARS = 5;
    localparam logic [7:0] X_MAX     = 8'(GRID_W - 1);
    localparam logic [7:0] Y_MAX     = 8'(GRID_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WRITE,
        S_COLLIDE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] pos_x [NUM_CHARS];
    logic [7:0] pos_y [NUM_CHARS];

    logic [2:0] cur_id;
    logic [1:0] cur_dir;
    logic [7:0] new_x;
    logic [7:0] new_y;

    logic       handshake;
    logic       id_ok;
    logic [7:0] cur_x;
    logic [7:0] cur_y;
    logic [7:0] calc_x;
    logic [7:0] calc_y;
    logic       hit;

    // move_ready is registered and only ever high while the FSM sits in
    // S_IDLE, so a handshake implies the FSM is idle.
    assign handshake = mv.move_valid && mv.move_ready && (state == S_IDLE);
    // Ids 5..7 travel through the FSM but never touch state.
    assign id_ok     = (cur_id < 3'(NUM_CHARS));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        state_next = state;
        unique case (state)
            S_IDLE:    if (handshake) state_next = S_CALC;
            S_CALC:    state_next = S_WRITE;
            S_WRITE:   state_next = S_COLLIDE;
            S_COLLIDE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read port for the display stage
    // ------------------------------------------------------------------------
    always_comb begin
        char_x = 8'd0;
        char_y = 8'd0;
        if (character_type < 3'(NUM_CHARS)) begin
            char_x = pos_x[character_type];
            char_y = pos_y[character_type];
        end
    end

    // ------------------------------------------------------------------------
    // Next position of the character being moved, with edge handling
    // ------------------------------------------------------------------------
    always_comb begin
        cur_x = 8'd0;
        cur_y = 8'd0;
        if (id_ok) begin
            cur_x = pos_x[cur_id];
            cur_y = pos_y[cur_id];
        end

        calc_x = cur_x;
        calc_y = cur_y;
        unique case (cur_dir)
            2'd0: begin
                if (cur_x == 8'd0) calc_x = WRAP ? X_MAX : 8'd0;
                else               calc_x = cur_x - 8'd1;
            end
            2'd1: begin
                if (cur_x >= X_MAX) calc_x = WRAP ? 8'd0 : X_MAX;
                else                calc_x = cur_x + 8'd1;
            end
            2'd2: begin
                if (cur_y != 8'd0) calc_y = cur_y - 8'd1;
            end
            default: begin
                if (cur_y < Y_MAX) calc_y = cur_y + 8'd1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pacman against each ghost; ghost/ghost overlaps are not of interest
    // ------------------------------------------------------------------------
    always_comb begin
        hit = 1'b0;
        for (int k = 1; k < NUM_CHARS; k++) begin
            if ((pos_x[k] == pos_x[0]) && (pos_y[k] == pos_y[0])) hit = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state              <= S_IDLE;
            mv.move_ready      <= 1'b0;
            cur_id             <= 3'd0;
            cur_dir            <= 2'd0;
            new_x              <= 8'd0;
            new_y              <= 8'd0;
            pacman_orientation <= 1'b0;
            collision          <= 1'b0;
            // NOTE: the position array is only five flop pairs holding the
            // visible start positions, so it is reset like any other state
            // rather than treated as an unreset memory.
            pos_x[0]           <= 8'(PAC_X0);
            pos_y[0]           <= 8'(PAC_Y0);
            for (int k = 1; k < NUM_CHARS; k++) begin
                pos_x[k] <= 8'(GHOST_X0 + k - 1);
                pos_y[k] <= 8'(GHOST_Y0);
            end
        end else begin
            state         <= state_next;
            // hold is only looked at here, i.e. when deciding whether the
            // idle FSM offers ready; an accepted move always completes.
            mv.move_ready <= (state_next == S_IDLE) && !mv.hold;

            if (handshake) begin
                cur_id  <= mv.move_id;
                cur_dir <= mv.move_dir;
            end

            if (state == S_CALC) begin
                new_x <= calc_x;
                new_y <= calc_y;
            end

            if ((state == S_WRITE) && id_ok) begin
                pos_x[cur_id] <= new_x;
                pos_y[cur_id] <= new_y;
                // Facing follows the requested direction even when the move
                // itself was clamped at the edge.
                if ((cur_id == 3'd0) && !cur_dir[1]) begin
                    pacman_orientation <= cur_dir[0];
                end
            end

            // A set in S_COLLIDE takes priority over a simultaneous clear.
            if ((state == S_COLLIDE) && id_ok && hit) begin
                collision <= 1'b1;
            end else if (collision_clear) begin
                collision <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_character_registers.sv
// ----------------------------------------------------------------------------
// tb_character_registers
//   Directed bench for character_registers. The stimulus process issues moves
//   and pushes the expected outcome of each into a queue; an independent
//   monitor process detects every handshake on the bus, pops the matching
//   expectation and checks ready timing, the written position, orientation
//   and the collision flag at the cycle offsets the design promises.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_character_registers;

    localparam int DRV = 3;   // inputs change 3 ns after the rising edge

    logic       clock_50 = 1'b0;
    logic       reset;
    logic [2:0] stim_sel;
    logic [2:0] mon_sel;
    logic       mon_active;
    logic [2:0] character_type;
    logic [7:0] char_x;
    logic [7:0] char_y;
    logic       pacman_orientation;
    logic       collision;
    logic       collision_clear;

    always #5 clock_50 = ~clock_50;

    // The monitor borrows the read port while checking a finished move.
    assign character_type = mon_active ? mon_sel : stim_sel;

    character_registers_if mv_if ();

    character_registers dut (
        .clock_50           (clock_50),
        .reset              (reset),
        .character_type     (character_type),
        .char_x             (char_x),
        .char_y             (char_y),
        .pacman_orientation (pacman_orientation),
        .mv                 (mv_if),
        .collision          (collision),
        .collision_clear    (collision_clear)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string      name;
        logic [2:0] id;
        int         x;
        int         y;
        logic       orient;
        logic       coll;
        bit         check_pos;
        bit         skip;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of the positions and flags
    int   mx [5];
    int   my [5];
    logic morient;
    logic mcoll;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        mx      = '{10, 9, 10, 11, 12};
        my      = '{12, 6, 6, 6, 6};
        morient = 1'b0;
        mcoll   = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] id, input logic [1:0] dir,
                              input bit clr, output exp_t e);
        bit hit;
        int i;
        hit         = 1'b0;
        e.id        = id;
        e.check_pos = (id < 3'd5);
        e.skip      = 1'b0;
        e.x         = 0;
        e.y         = 0;
        if (id < 3'd5) begin
            i = int'(id);
            case (dir)
`ifdef CHARACTER_REGISTERS_WRAP_TUNNEL_EN
                2'd0: mx[i] = (mx[i] == 0)  ? 21 : mx[i] - 1;
                2'd1: mx[i] = (mx[i] == 21) ? 0  : mx[i] + 1;
`else
                2'd0: mx[i] = (mx[i] == 0)  ? 0  : mx[i] - 1;
                2'd1: mx[i] = (mx[i] == 21) ? 21 : mx[i] + 1;
`endif
                2'd2: my[i] = (my[i] == 0)  ? 0  : my[i] - 1;
                default: my[i] = (my[i] == 15) ? 15 : my[i] + 1;
            endcase
            if ((id == 3'd0) && (dir < 2'd2)) morient = dir[0];
            for (int k = 1; k < 5; k++)
                if ((mx[k] == mx[0]) && (my[k] == my[0])) hit = 1'b1;
            if (hit)      mcoll = 1'b1;
            else if (clr) mcoll = 1'b0;
            e.x = mx[i];
            e.y = my[i];
        end else if (clr) begin
            mcoll = 1'b0;
        end
        e.orient = morient;
        e.coll   = mcoll;
    endtask

    task automatic read_check(input string name, input logic [2:0] t,
                              input int ex, input int ey);
        stim_sel = t;
        #0.1;
        check({name, "_x"}, 32'(char_x), ex);
        check({name, "_y"}, 32'(char_y), ey);
    endtask

    task automatic read_model(input string name);
        for (int k = 0; k < 5; k++) read_check(name, 3'(k), mx[k], my[k]);
    endtask

    // Waits (bounded) until move_ready is offered. Returns 0 on timeout.
    task automatic wait_ready(input string name, output bit ok);
        int n;
        n = 0;
        while (mv_if.move_ready !== 1'b1 && n < 50) begin
            @(posedge clock_50); #DRV;
            n++;
        end
        ok = (mv_if.move_ready === 1'b1);
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_ready_timeout: move_ready never rose within 50 cycles", name);
        end
    endtask

    // One complete move; returns 3 ns after edge N+3.
    task automatic do_move(input string name, input logic [2:0] id,
                           input logic [1:0] dir, input bit clr_at_n3 = 1'b0,
                           input bit hold_after = 1'b0);
        exp_t e;
        bit   ok;
        model_step(id, dir, clr_at_n3, e);
        e.name = name;
        exp_q.push_back(e);
        mv_if.move_valid = 1'b1;
        mv_if.move_id    = id;
        mv_if.move_dir   = dir;
        wait_ready(name, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            mv_if.move_valid = 1'b0;
            return;
        end
        @(posedge clock_50); #DRV;          // edge N: handshake
        mv_if.move_valid = 1'b0;
        if (hold_after) mv_if.hold = 1'b1;
        @(posedge clock_50); #DRV;          // edge N+1
        @(posedge clock_50); #DRV;          // edge N+2
        if (clr_at_n3) collision_clear = 1'b1;
        @(posedge clock_50); #DRV;          // edge N+3
        collision_clear = 1'b0;
    endtask

    task automatic clear_pulse(input string name);
        collision_clear = 1'b1;
        @(posedge clock_50); #DRV;
        collision_clear = 1'b0;
        mcoll = 1'b0;
        check(name, 32'(collision), 0);
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        mon_active = 1'b0;
        mon_sel    = 3'd0;
        forever begin
            @(negedge clock_50);
            if (reset === 1'b0 && mv_if.move_valid === 1'b1 &&
                mv_if.move_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_handshake: id %0d dir %0d accepted, none expected",
                             mv_if.move_id, mv_if.move_dir);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.skip) begin
                        @(posedge clock_50); #1;   // after edge N
                        check({e.name, "_ready_n0"}, 32'(mv_if.move_ready), 0);
                        @(posedge clock_50); #1;   // after edge N+1
                        check({e.name, "_ready_n1"}, 32'(mv_if.move_ready), 0);
                        @(posedge clock_50); #1;   // after edge N+2
                        check({e.name, "_ready_n2"}, 32'(mv_if.move_ready), 0);
                        if (e.check_pos) begin
                            mon_sel    = e.id;
                            mon_active = 1'b1;
                            #0.1;
                            check({e.name, "_x"}, 32'(char_x), e.x);
                            check({e.name, "_y"}, 32'(char_y), e.y);
                            mon_active = 1'b0;
                        end
                        check({e.name, "_orient"}, 32'(pacman_orientation), 32'(e.orient));
                        @(posedge clock_50); #1;   // after edge N+3
                        check({e.name, "_collision"}, 32'(collision), 32'(e.coll));
                        check({e.name, "_ready_n3"}, 32'(mv_if.move_ready),
                              32'(!mv_if.hold));
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        bit   ok;
        int   n;

        reset            = 1'b1;
        stim_sel         = 3'd0;
        mv_if.hold       = 1'b0;
        mv_if.move_valid = 1'b0;
        mv_if.move_id    = 3'd0;
        mv_if.move_dir   = 2'd0;
        collision_clear  = 1'b0;
        model_reset();

        // ---- reset state ----------------------------------------------------
        repeat (3) @(posedge clock_50);
        #DRV;
        check("ready_in_reset", 32'(mv_if.move_ready), 0);
        reset = 1'b0;
        read_check("rst_pac",    3'd0, 10, 12);
        read_check("rst_ghost1", 3'd1, 9, 6);
        read_check("rst_ghost2", 3'd2, 10, 6);
        read_check("rst_ghost3", 3'd3, 11, 6);
        read_check("rst_ghost4", 3'd4, 12, 6);
        read_check("rst_type5",  3'd5, 0, 0);
        read_check("rst_type7",  3'd7, 0, 0);
        check("rst_orient",    32'(pacman_orientation), 0);
        check("rst_collision", 32'(collision), 0);
        @(posedge clock_50); #DRV;
        check("ready_after_reset", 32'(mv_if.move_ready), 1);

        // ---- basic pacman moves --------------------------------------------
        do_move("pac_right", 3'd0, 2'd1);
        read_check("pac_right_rd", 3'd0, 11, 12);
        check("pac_right_orient", 32'(pacman_orientation), 1);
        do_move("pac_left", 3'd0, 2'd0);

        // ---- ghost 1 onto pacman, sticky flag and clear ---------------------
        do_move("g1_right", 3'd1, 2'd1);
        for (int i = 0; i < 5; i++) do_move("g1_down", 3'd1, 2'd3);
        read_check("g1_above_pac", 3'd1, 10, 11);
        check("no_collision_yet", 32'(collision), 0);
        do_move("g1_onto_pac", 3'd1, 2'd3);
        check("collision_set", 32'(collision), 1);
        do_move("g1_off_pac", 3'd1, 2'd2);
        check("collision_sticky", 32'(collision), 1);
        clear_pulse("collision_cleared");
        do_move("g1_set_vs_clear", 3'd1, 2'd3, 1'b1);
        check("set_beats_clear", 32'(collision), 1);
        do_move("g1_leave", 3'd1, 2'd2);
        clear_pulse("collision_cleared2");

        // ---- horizontal edge: pacman to x=0 and beyond ----------------------
        for (int i = 0; i < 11; i++) do_move("pac_to_left_edge", 3'd0, 2'd0);
`ifdef CHARACTER_REGISTERS_WRAP_TUNNEL_EN
        read_check("pac_left_edge", 3'd0, 21, 12);
`else
        read_check("pac_left_edge", 3'd0, 0, 12);
`endif
        check("pac_left_edge_orient", 32'(pacman_orientation), 0);

        // ---- vertical edges -------------------------------------------------
        for (int i = 0; i < 7; i++) do_move("g3_up_edge", 3'd3, 2'd2);
        read_check("g3_top_edge", 3'd3, 11, 0);
        for (int i = 0; i < 10; i++) do_move("g4_down_edge", 3'd4, 2'd3);
        read_check("g4_bottom_edge", 3'd4, 12, 15);
        for (int i = 0; i < 10; i++) do_move("g4_right_edge", 3'd4, 2'd1);
`ifdef CHARACTER_REGISTERS_WRAP_TUNNEL_EN
        read_check("g4_right_edge_rd", 3'd4, 0, 15);
`else
        read_check("g4_right_edge_rd", 3'd4, 21, 15);
`endif

        // ---- hold blocks new moves ------------------------------------------
        mv_if.hold = 1'b1;
        @(posedge clock_50); #DRV;
        check("ready_low_on_hold", 32'(mv_if.move_ready), 0);
        mv_if.move_valid = 1'b1;
        mv_if.move_id    = 3'd0;
        mv_if.move_dir   = 2'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock_50); #DRV;
            check("ready_held_low", 32'(mv_if.move_ready), 0);
        end
        mv_if.move_valid = 1'b0;
        mv_if.hold       = 1'b0;
        read_model("hold_no_change");
        @(posedge clock_50); #DRV;
        check("ready_after_hold", 32'(mv_if.move_ready), 1);

        // ---- hold raised after a handshake: move still completes ------------
        do_move("pac_up_hold_after", 3'd0, 2'd2, 1'b0, 1'b1);
        check("ready_low_held_idle", 32'(mv_if.move_ready), 0);
        mv_if.hold = 1'b0;
        @(posedge clock_50); #DRV;
        check("ready_after_hold2", 32'(mv_if.move_ready), 1);

        // ---- out-of-range id: accepted, no state change ---------------------
        do_move("id6_move", 3'd6, 2'd1);
        read_model("id6_no_change");

        // ---- reset during S_CALC aborts the move ----------------------------
        do_move("pac_right_pre_abort", 3'd0, 2'd1);
        e.name      = "abort";
        e.id        = 3'd2;
        e.x         = 0;
        e.y         = 0;
        e.orient    = 1'b0;
        e.coll      = 1'b0;
        e.check_pos = 1'b0;
        e.skip      = 1'b1;
        exp_q.push_back(e);
        mv_if.move_valid = 1'b1;
        mv_if.move_id    = 3'd2;
        mv_if.move_dir   = 2'd0;
        wait_ready("abort", ok);
        if (!ok) void'(exp_q.pop_back());
        @(posedge clock_50); #DRV;          // edge N: handshake, FSM in S_CALC
        mv_if.move_valid = 1'b0;
        reset            = 1'b1;
        @(posedge clock_50); #DRV;          // edge N+1 sees reset
        check("abort_ready",     32'(mv_if.move_ready), 0);
        check("abort_orient",    32'(pacman_orientation), 0);
        check("abort_collision", 32'(collision), 0);
        read_check("abort_pac",    3'd0, 10, 12);
        read_check("abort_ghost2", 3'd2, 10, 6);
        read_check("abort_ghost4", 3'd4, 12, 6);
        model_reset();
        reset = 1'b0;
        @(posedge clock_50); #DRV;
        check("abort_ready_back", 32'(mv_if.move_ready), 1);
        repeat (4) @(posedge clock_50);
        #DRV;
        read_model("abort_no_resume");

        // ---- normal operation after the abort -------------------------------
        do_move("pac_right_post_abort", 3'd0, 2'd1);

        // ---- drain scoreboard -----------------------------------------------
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clock_50);
            n++;
        end
        repeat (2) @(posedge clock_50);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/character_registers.md
Name: character_registers

Overview:
- Position store for the five on-screen characters: id 0 = pacman, ids 1-4 = ghosts.
- Feeds the character display stage through a combinational read port indexed by that stage's character_type; also supplies pacman_orientation.
- Upstream game logic applies moves through a valid/ready handshake; the block clamps or wraps moves at the grid edges and flags pacman/ghost collisions.

Parameters:
- GRID_W, 22: grid columns; legal x = 0..GRID_W-1.
- GRID_H, 16: grid rows; legal y = 0..GRID_H-1.
- PAC_X0, 10: pacman reset x.
- PAC_Y0, 12: pacman reset y.
- GHOST_X0, 9: reset x of ghost 1; ghost k resets to GHOST_X0+k-1.
- GHOST_Y0, 6: reset y of all ghosts.

Ports:
- clock_50  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- character_type  in  3  read index from the display stage.
- char_x  out  8  x of the indexed character, combinational.
- char_y  out  8  y of the indexed character, combinational.
- pacman_orientation  out  1  0 = facing left, 1 = facing right.
- hold  in  1  1 = stall new moves (display frame in progress).
- move_valid  in  1  move request present.
- move_id  in  3  character to move.
- move_dir  in  2  0 = left, 1 = right, 2 = up, 3 = down.
- move_ready  out  1  block can accept a move this cycle.
- collision  out  1  sticky pacman/ghost overlap flag.
- collision_clear  in  1  clears collision.

Behaviour:
- Clock is clock_50; reset is synchronous, active-high (decided).
- Reset values:
  - Positions go to their parameter values.
  - pacman_orientation=0, collision=0, FSM in S_IDLE.
  - move_ready=0 during reset; it is registered and first reads 1 the cycle after reset deasserts.
- Read port:
  - char_x/char_y follow character_type combinationally, with no latency.
  - character_type 5..7 returns 0/0.
  - Both outputs are zero-extended to 8 bits.
- move_ready is 1 only in S_IDLE with hold=0.
- A handshake occurs on a rising edge where move_valid=1 and move_ready=1. At that edge move_id and move_dir are registered and the FSM goes to S_CALC.
- S_CALC (1 cycle): compute the next position. Edge rules:
  - left at x=0: stays 0.
  - right at x=GRID_W-1: stays.
  - up at y=0: stays.
  - down at y=GRID_H-1: stays.
  - Arithmetic is unsigned 8-bit; results never leave the grid.
- S_WRITE (1 cycle): store the new position.
  - If move_id=0 and dir is left or right, pacman_orientation is set to 0 or 1 respectively, even when the move is clamped.
  - Up/down leaves orientation unchanged.
- S_COLLIDE (1 cycle): compare pacman against ghosts 1-4. Any exact x and y match sets collision. Return to S_IDLE.
- Timing, for a handshake at edge N:
  - Position is visible on the read port after edge N+2.
  - collision is updated at edge N+3.
  - move_ready is high again after edge N+3 if hold=0.
  - Throughput: one move per 4 cycles.
- move_id 5..7: still handshaken and passes through the FSM, but writes nothing and the collision check is skipped.
- hold is sampled only in S_IDLE. A move already accepted completes regardless of hold.
- collision_clear:
  - Clears collision at the next edge.
  - If it coincides with a set in S_COLLIDE, the set wins.
- Reset asserted mid-move aborts the move; all state returns to reset values and the pending request is discarded.
- move_valid with move_ready=0 has no effect. The requester holds the request until ready.

Optional Feature:
- Macro: CHARACTER_REGISTERS_WRAP_TUNNEL_EN.
- Defined: horizontal moves wrap. Left at x=0 goes to GRID_W-1; right at GRID_W-1 goes to 0. Vertical moves still clamp.
- Undefined: all four edges clamp as above.

Test Plan:
- Reset, then read character_type 0..4 -> (10,12), (9,6), (10,6), (11,6), (12,6); type 5 -> (0,0); move_ready=1 the cycle after reset drops.
- Move id0 dir1 handshaken at edge N -> char_x=11 for type 0 after edge N+2; pacman_orientation=1; move_ready low for 3 cycles then high.
- Pacman at x=0, dir0 -> x stays 0, orientation=0; with the wrap macro defined -> x=21.
- Move ghost1 onto pacman (pacman at (10,12), ghost at (10,11), dir3) -> collision=1 at N+3 and stays 1; collision_clear pulse -> 0; clear on the same edge as a new set -> stays 1.
- hold=1 with move_valid=1 for 10 cycles -> no handshake, positions unchanged; hold raised the cycle after a handshake -> that move still completes.
- Reset asserted during S_CALC -> no position change, all outputs at reset values the next cycle; move_id=6 -> handshaken, no state change.
